// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
//
// Purpose: FSM state encoding and the default operand width used by
// serial_adder and its bench.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - combinational one-bit full adder
//
// Purpose: single full-adder cell reused every cycle by serial_adder.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   sum   out  a ^ b ^ cin
//   cout  out  carry out
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with start/done handshake
//
// Purpose: adds a + b + cin one bit per cycle, LSB first, through a single
// fa_bit cell with a registered carry loop. Result appears WIDTH cycles
// after an accepted start.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE or DONE
//   a, b   in   operands, captured on accepted start
//   cin    in   initial carry, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  registered result, holds until next completion
//   cout   out  registered final carry, holds until next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, res;
  logic [WIDTH-1:0] res_nxt;
  logic             c;
  logic             fa_s, fa_co;
  logic             accept;
  logic             last_bit;

  fa_bit u_fa (
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (c),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // start is only honoured between adds; DONE->RUN gives back-to-back adds.
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
  assign res_nxt  = {fa_s, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      ra  <= a;
      rb  <= b;
      c   <= cin;
      cnt <= '0;
      res <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      c   <= fa_co;
      res <= res_nxt;
      cnt <= cnt + CNT_W'(1);
      // Publish on the same edge that moves RUN->DONE.
      if (last_bit) begin
        sum  <= res_nxt;
        cout <= fa_co;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial multi-bit adder built around a single one-bit full-adder cell with a registered carry loop. It sits directly downstream of the team's combinational one-bit full adder: the sum bit is consumed into a shift register and carry-out is fed back as the next carry-in. The result is a WIDTH-bit add in WIDTH cycles behind a start/done handshake. It is the first sequential datapath block in the lab series.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits (≥2).

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on accepted start.
- `b`  in  WIDTH  operand B; captured on accepted start.
- `cin`  in  1  initial carry-in; captured on accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result; holds until next completion.
- `cout`  out  1  final carry-out; holds until next completion.

## Operation
- FSM states:
  - IDLE: waiting.
  - RUN: one bit per cycle, LSB first.
  - DONE: one cycle; publish the result.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when bit counter = WIDTH-1 at the edge.
  - DONE→RUN if `start` is high, else DONE→IDLE.
- Accepted start:
  - Load shift registers `ra=a`, `rb=b`.
  - Load carry register `c=cin`.
  - Clear bit counter and result shift register.
- Each RUN edge:
  - Compute s, co = FA(`ra[0]`, `rb[0]`, `c`).
  - `c<=co`.
  - Shift `ra`, `rb` right by 1.
  - Shift s into the result MSB (result register shifts right).
  - Counter increments.
- Entering DONE: `sum` <= completed result register and `cout` <= final carry, both in the same edge.
- `start` is ignored in RUN. Inputs `a`, `b`, `cin` are don't-care except at an accepted start.
- Arithmetic: {`cout`,`sum`} = `a`+`b`+`cin`, modulo 2^(WIDTH+1). No overflow flag.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `sum`=0, `cout`=0
  - internal registers 0
- Reset is effective immediately, including mid-RUN. The partial result is discarded and `sum`/`cout` clear to 0.
- `start` accepted at edge E0:
  - `busy`=1 after E0 through edge E0+WIDTH.
  - `done`=1 for exactly the cycle after edge E0+WIDTH, with `busy`=0.
  - Latency from start edge to `done` is WIDTH cycles. `sum`/`cout` change only at that edge.
- Back-to-back: `start` held high during DONE is accepted at that edge. `busy` rises again with no idle cycle, giving a throughput of one add per WIDTH+1 cycles.
- `done` and `busy` are never high together.

## Structure
- Package `serial_adder_pkg`: `state_t` enum {IDLE, RUN, DONE} and the default `WIDTH` constant.
- Sub-module `fa_bit`: purely combinational one-bit full adder (`a`, `b`, `cin` → `sum`, `cout`). It is instantiated once.
- Top holds the FSM, counter ($clog2(WIDTH) bits), operand/result shift registers, carry register and output registers.

## Test plan
Scenarios 1–6 use WIDTH=8.
1. `a`=0x00, `b`=0x00, `cin`=0, pulse `start` → `busy` for 8 cycles, then `done` pulse; `sum`=0x00, `cout`=0.
2. `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1 at `done`; values hold after `done` falls.
3. `a`=0xA5, `b`=0x5A, `cin`=1 → `sum`=0x00, `cout`=1. `a`=0x7F, `b`=0x01, `cin`=0 → `sum`=0x80, `cout`=0.
4. Pulse `start` with new operands at cycle 3 of RUN → ignored; result still matches the first operands and `done` occurs exactly once.
5. Assert `reset` asynchronously at RUN bit 4 → `busy`/`done`/`sum`/`cout` go 0 immediately. After release, a new add 0x12+0x34 gives `sum`=0x46, `cout`=0.
6. Hold `start` high continuously with 0x01+0x01 then 0x80+0x80 → `done` pulses 9 cycles apart with `sum`=0x02/`cout`=0, then `sum`=0x00/`cout`=1. Also exhaustively sweep WIDTH=2 (all a, b, cin) against a+b+cin.
